input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 199 +++++++++++++++++++
 tb/tb_input_conditioner.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Purpose : synchronizes and debounces one asynchronous input, reports committed edges and rejected glitches.
// Latency : a held change reaches dout on edge SYNC_STAGES+DEBOUNCE_CYCLES after din_async is first sampled.
// Backpres: none; a sample is taken every cycle and nothing can stall the block.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous, active-high reset
//   din_async   raw input with no timing relationship to clk
//   en          debounce enable, synchronous to clk
//   dout        registered debounced level
//   rise_pulse  one-cycle strobe on a committed 0->1
//   fall_pulse  one-cycle strobe on a committed 1->0
//   glitch_cnt  saturating count of rejected transitions
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din_async,
  input  logic       en,
  output logic       dout,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [7:0] glitch_cnt
);

  // ---------------------------------------------------------------------------
  // Parameter legality
  // ---------------------------------------------------------------------------
  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
      $error("input_conditioner: SYNC_STAGES must be in 2..4");
    end
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce_cycles
      $error("input_conditioner: DEBOUNCE_CYCLES must be in 2..65535");
    end
  endgenerate

  // The counter only ever has to reach DEBOUNCE_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    ST_CHK_H = 2'd1,
    ST_HIGH  = 2'd2,
    ST_CHK_L = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizer: only the last stage is allowed anywhere near the FSM.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_async};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // en=0 in a check state abandons the candidate edge without calling it a
  // glitch; en=0 in a settled state simply holds.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOW: begin
        if (en && s) begin
          state_d = ST_CHK_H;
          cnt_d   = CNT_ONE;
        end
      end
      ST_CHK_H: begin
        if (!en || !s) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (en && !s) begin
          state_d = ST_CHK_L;
          cnt_d   = CNT_ONE;
        end
      end
      ST_CHK_L: begin
        if (!en || s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM output logic
  // Commit and glitch are decoded from the same state and mutually exclusive
  // conditions on s, so they can never coincide.
  // ---------------------------------------------------------------------------
  logic       commit_rise;
  logic       commit_fall;
  logic       glitch;
  logic       dout_d;
  logic [7:0] glitch_cnt_d;

  always_comb begin
    commit_rise  = 1'b0;
    commit_fall  = 1'b0;
    glitch       = 1'b0;
    dout_d       = dout;
    glitch_cnt_d = glitch_cnt;

    case (state_q)
      ST_CHK_H: begin
        commit_rise = en && s && (cnt_q == CNT_MAX);
        glitch      = en && !s;
      end
      ST_CHK_L: begin
        commit_fall = en && !s && (cnt_q == CNT_MAX);
        glitch      = en && s;
      end
      default: begin
        commit_rise = 1'b0;
        commit_fall = 1'b0;
        glitch      = 1'b0;
      end
    endcase

    if (commit_rise) begin
      dout_d = 1'b1;
    end else if (commit_fall) begin
      dout_d = 1'b0;
    end

    // Saturate rather than wrap so a storm of glitches stays visible.
    if (glitch && (glitch_cnt != 8'hFF)) begin
      glitch_cnt_d = glitch_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      glitch_cnt <= 8'd0;
    end else begin
      dout       <= dout_d;
      rise_pulse <= commit_rise;
      fall_pulse <= commit_fall;
      glitch_cnt <= glitch_cnt_d;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Purpose : checks input_conditioner against a run-length reference model through a per-cycle scoreboard.
// Latency : one expectation is queued per rising edge and consumed on the following falling edge.
// Backpres: none; the DUT produces an observation every cycle.
module tb_input_conditioner;

  localparam int SYNC = 2;
  localparam int DC   = 4;

  logic       clk;
  logic       rst;
  logic       din_async;
  logic       en;
  logic       dout;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] glitch_cnt;

  input_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din_async (din_async),
    .en        (en),
    .dout      (dout),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .glitch_cnt(glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       dout;
    logic       rise;
    logic       fall;
    logic [7:0] gcnt;
  } obs_t;

  obs_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: committed level plus the length of the current run of
  // synchronized samples that disagree with it.
  bit hist[$];
  bit m_lvl;
  int m_run;
  int m_glitch;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
    m_lvl    = 1'b0;
    m_run    = 0;
    m_glitch = 0;
  endtask

  task automatic model_edge();
    obs_t e;
    bit   s;
    bit   r;
    bit   f;
    r = 1'b0;
    f = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      s = hist.pop_front();
      hist.push_back(din_async);
      if (!en) begin
        m_run = 0;
      end else if (s != m_lvl) begin
        m_run++;
        if (m_run == DC) begin
          m_lvl = s;
          if (s) r = 1'b1;
          else   f = 1'b1;
          m_run = 0;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
    end
    e.dout = m_lvl;
    e.rise = r;
    e.fall = f;
    e.gcnt = 8'(m_glitch);
    sb.push_back(e);
  endtask

  // Drive inputs away from the edge, take one edge, queue its expectation.
  task automatic step(input logic d, input logic e);
    din_async = d;
    en        = e;
    @(posedge clk);
    model_edge();
    #2;
  endtask

  // Reset asserted between edges: outputs must read zero before the next edge.
  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    sb.delete();
    model_reset();
    sb.push_back(obs_t'(0));
    for (int i = 0; i < n; i++) step(din_async, en);
    rst = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic measure(input logic d, output int n);
    n = 0;
    do begin
      step(d, 1'b1);
      n++;
    end while (dout !== d && n < 20);
  endtask

  // Monitor: every falling edge presents one observation.
  initial begin
    obs_t exp;
    obs_t act;
    forever begin
      @(negedge clk);
      act = {dout, rise_pulse, fall_pulse, glitch_cnt};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard: observation %b/%b/%b/%0d with no expectation queued",
                 act.dout, act.rise, act.fall, act.gcnt);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          failures++;
          $display("FAIL scoreboard: dout/rise/fall/glitch got %b/%b/%b/%0d expected %b/%b/%b/%0d at %0t",
                   act.dout, act.rise, act.fall, act.gcnt,
                   exp.dout, exp.rise, exp.fall, exp.gcnt, $time);
        end
      end
    end
  end

  initial begin
    int n;
    logic d;
    logic e;
    int len;

    rst       = 1'b1;
    din_async = 1'b0;
    en        = 1'b0;
    model_reset();
    #1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;

    // Clean rise: six edges from first sample to commit.
    repeat (3) step(1'b0, 1'b1);
    measure(1'b1, n);
    check("rise_latency", n, SYNC + DC);
    check("rise_pulse_at_commit", int'(rise_pulse), 1);
    step(1'b1, 1'b1);
    check("rise_pulse_after", int'(rise_pulse), 0);
    check("glitch_after_rise", int'(glitch_cnt), 0);
    repeat (2) step(1'b1, 1'b1);

    // Clean fall.
    measure(1'b0, n);
    check("fall_latency", n, SYNC + DC);
    check("fall_pulse_at_commit", int'(fall_pulse), 1);
    repeat (3) step(1'b0, 1'b1);

    // Two-sample glitch.
    repeat (2) step(1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b1);
    check("glitch_one", int'(glitch_cnt), 1);
    check("glitch_dout", int'(dout), 0);

    // Enable dropped during CHK_H.
    repeat (3) step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1);
    check("en_abort_dout", int'(dout), 0);
    check("en_abort_glitch", int'(glitch_cnt), 1);

    // Reset while HIGH with din held high.
    repeat (8) step(1'b1, 1'b1);
    check("reached_high", int'(dout), 1);
    do_reset(2);
    din_async = 1'b0;

    // Reset pulse during CHK_H, then din low: no pulse may follow.
    repeat (3) step(1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1);
    do_reset(1);
    repeat (8) step(1'b0, 1'b1);
    check("rst_abort_dout", int'(dout), 0);
    check("rst_abort_glitch", int'(glitch_cnt), 0);

    // Saturation: 300 two-sample glitches.
    for (int i = 0; i < 300; i++) begin
      repeat (2) step(1'b1, 1'b1);
      repeat (2) step(1'b0, 1'b1);
    end
    repeat (3) step(1'b0, 1'b1);
    check("glitch_saturated", int'(glitch_cnt), 255);
    check("sat_dout", int'(dout), 0);

    // Randomized runs with occasional enable drops and resets.
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      d   = 1'($urandom_range(0, 1));
      e   = ($urandom_range(0, 9) != 0);
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) step(d, e);
      if ($urandom_range(0, 99) == 0) do_reset(1);
    end

    repeat (2) step(din_async, en);
    #5;
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
